// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared state encoding for the two-entry skid buffer
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [1:0] STATE_ILLEGAL = 2'd3;

  function automatic logic state_has_beat(input logic [1:0] s);
    return (s != EMPTY);
  endfunction

  function automatic logic state_can_accept(input logic [1:0] s);
    return (s != FULL);
  endfunction

endpackage

// File: rtl/skid_ctrl.sv
// rtl/skid_ctrl.sv - occupancy FSM producing datapath load enables
module skid_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic [1:0] state,
  output logic       load_main,
  output logic       load_skid,
  output logic       main_sel_skid
);
  import skid_pkg::*;

  skid_state_t state_q;
  skid_state_t state_d;
  logic        in_fire;
  logic        out_fire;

  // Handshakes derive from registered state only, so no input reaches in_ready/out_valid.
  assign in_fire  = in_valid & state_can_accept(state_q);
  assign out_fire = out_ready & state_has_beat(state_q);

  always_comb begin
    state_d       = state_q;
    load_main     = 1'b0;
    load_skid     = 1'b0;
    main_sel_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main     = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a beat offered this cycle.
    if (flush) begin
      state_d       = EMPTY;
      load_main     = 1'b0;
      load_skid     = 1'b0;
      main_sel_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry ready/valid pipeline stage with registered handshakes
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  import skid_pkg::*;

  logic [1:0]       state;
  logic             load_main;
  logic             load_skid;
  logic             main_sel_skid;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d;

  skid_ctrl u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .state         (state),
    .load_main     (load_main),
    .load_skid     (load_skid),
    .main_sel_skid (main_sel_skid)
  );

  assign main_d = main_sel_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign out_data  = main_q;
  assign out_valid = state_has_beat(state);
  assign in_ready  = state_can_accept(state) & ~reset;
  assign count     = state;

endmodule

// File: tb/tb_skid_buffer.sv
// tb/tb_skid_buffer.sv - directed and scoreboard checks for skid_buffer
module tb_skid_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int vectors;
  int miscompares;
  logic [31:0] sb[$];

  skid_buffer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] c, input logic r);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".count"}, {30'd0, count}, {30'd0, c});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
  endtask

  initial begin
    logic       iv;
    logic       ordy;
    logic       fl;
    logic       prev_stall;
    logic [31:0] prev_data;
    vectors     = 0;
    miscompares = 0;

    // reset with a beat offered: nothing may be captured
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.count", {30'd0, count}, 32'd0);
    chk("rst.main", out_data, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk_out("post_rst", 1'b0, 32'd0, 2'd0, 1'b1);

    // full-throughput stream
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, i, 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk_out("stream_drain", 1'b0, 32'd0, 2'd0, 1'b1);

    // backpressure into FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA0;
    tick();
    chk_out("bp_a0", 1'b1, 32'hA0, 2'd1, 1'b1);
    in_data = 32'hA1;
    tick();
    chk_out("bp_a1", 1'b1, 32'hA0, 2'd2, 1'b0);
    in_data = 32'hA2;
    tick();
    chk_out("bp_hold", 1'b1, 32'hA0, 2'd2, 1'b0);

    // leaving FULL: only the output fires, pending beat taken next cycle
    out_ready = 1'b1;
    tick();
    chk_out("bp_rel1", 1'b1, 32'hA1, 2'd1, 1'b1);
    tick();
    chk_out("bp_rel2", 1'b1, 32'hA2, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("bp_drain", 1'b0, 32'd0, 2'd0, 1'b1);

    // flush while FULL with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB0;
    tick();
    in_data = 32'hB1;
    tick();
    chk_out("fl_full", 1'b1, 32'hB0, 2'd2, 1'b0);
    flush = 1'b1; in_data = 32'h55;
    tick();
    chk_out("fl_empty", 1'b0, 32'd0, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_out("fl_quiet", 1'b0, 32'd0, 2'd0, 1'b1);
    in_valid = 1'b1; in_data = 32'hC0;
    tick();
    chk_out("fl_new", 1'b1, 32'hC0, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();

    // reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
    tick();
    chk_out("mid_one", 1'b1, 32'hD0, 2'd1, 1'b1);
    reset = 1'b1;
    tick();
    chk("mid_rst.count", {30'd0, count}, 32'd0);
    chk("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst.main", out_data, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk_out("mid_after", 1'b0, 32'd0, 2'd0, 1'b1);

    // randomized traffic against a queue model
    sb.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int n = 0; n < 10000; n++) begin
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 99) == 0);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_data   = $urandom;
      #1;
      chk("rnd.count", {30'd0, count}, sb.size());
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      if (sb.size() != 0) chk("rnd.out_data", out_data, sb[0]);
      if (prev_stall && sb.size() != 0) chk("rnd.stable", out_data, prev_data);
      prev_stall = (sb.size() != 0) && !ordy && !fl;
      prev_data  = (sb.size() != 0) ? sb[0] : '0;
      if (ordy && sb.size() != 0) void'(sb.pop_front());
      if (iv && (sb.size() < 2 || (ordy && sb.size() == 1 && 0))) begin end
      if (fl) sb.delete();
      else if (iv && (sb.size() < 2) && !(sb.size() == 1 && count == 2'd2)) sb.push_back(in_data);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
